// File: rtl/sized_ram_ctrl.sv
// ============================================================================
// sized_ram_ctrl : big-endian byte RAM with sized, wait-stated load/store
// Optional atomic word swap compiled in with SIZED_RAM_SWAP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sized_ram_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  write,
    input  logic                  is_signed,
    input  logic [1:0]            size,
    input  logic                  swap,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [63:0]           data_in,
    output logic                  ready,
    output logic                  done,
    output logic [63:0]           data_out,
    output logic                  align_err
);

    localparam int         c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [2:0] c_WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam logic [1:0] c_SZ_BYTE   = 2'b00;
    localparam logic [1:0] c_SZ_HALF   = 2'b01;
    localparam logic [1:0] c_SZ_WORD   = 2'b10;
    localparam logic [1:0] c_SZ_DWORD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_XFER1 = 3'd2,
        S_XFER2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_wait_cnt;
    logic                    r_write;
    logic                    r_signed;
    logic [1:0]              r_size;
    logic                    r_swap;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [63:0]             r_data;
    logic                    r_err;
    logic [31:0]             r_hi;
    logic [63:0]             r_data_out;
    logic [7:0]              r_mem [c_DEPTH];

    logic                    w_accept;
    logic                    w_misalign;
    logic                    w_acc_err;
    logic                    w_do_store;
    logic                    w_do_load;
    logic                    w_xfer;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [ADDR_WIDTH-1:0]   w_lane_addr [4];
    logic [31:0]             w_rd_word;
    logic [31:0]             w_wr_word;
    logic [3:0]              w_wr_en;
    logic [63:0]             w_ld_value;

    assign w_accept = (r_state == S_IDLE) && req;
    assign w_xfer   = (r_state == S_XFER1) || (r_state == S_XFER2);

    always_comb begin
        w_misalign = 1'b0;
        case (size)
            c_SZ_HALF:  w_misalign = address[0];
            c_SZ_WORD:  w_misalign = (address[1:0] != 2'b00);
            c_SZ_DWORD: w_misalign = (address[2:0] != 3'b000);
            default:    w_misalign = 1'b0;
        endcase
    end

`ifdef SIZED_RAM_SWAP_EN
    // A swap reads the old word and writes the new one in the same transfer.
    assign w_acc_err  = w_misalign || (swap && (size != c_SZ_WORD));
    assign w_do_store = r_write || r_swap;
    assign w_do_load  = !r_write || r_swap;
`else
    logic w_unused_swap;
    assign w_unused_swap = r_swap;
    assign w_acc_err  = w_misalign;
    assign w_do_store = r_write;
    assign w_do_load  = !r_write;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_acc_err)             w_next = S_DONE;
                    else if (WAIT_STATES == 0) w_next = S_XFER1;
                    else                       w_next = S_WAIT;
                end
            end
            S_WAIT:  if (r_wait_cnt == 3'd0) w_next = S_XFER1;
            S_XFER1: w_next = (r_size == c_SZ_DWORD) ? S_XFER2 : S_DONE;
            S_XFER2: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The second half of a doubleword lives four bytes above the request address.
    assign w_base = (r_state == S_XFER2) ? r_addr + ADDR_WIDTH'(4) : r_addr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_lane_addr[i]           = w_base + ADDR_WIDTH'(i);
            w_rd_word[31-8*i -: 8]   = r_mem[w_lane_addr[i]];
        end
    end

    always_comb begin
        w_wr_word = r_data[31:0];
        w_wr_en   = 4'b1111;
        case (r_size)
            c_SZ_BYTE: begin
                w_wr_word = {r_data[7:0], 24'd0};
                w_wr_en   = 4'b0001;
            end
            c_SZ_HALF: begin
                w_wr_word = {r_data[15:0], 16'd0};
                w_wr_en   = 4'b0011;
            end
            c_SZ_DWORD: w_wr_word = (r_state == S_XFER2) ? r_data[31:0] : r_data[63:32];
            default:    w_wr_word = r_data[31:0];
        endcase
    end

    always_comb begin
        w_ld_value = {32'd0, w_rd_word};
        case (r_size)
            c_SZ_BYTE:  w_ld_value = {{56{r_signed & w_rd_word[31]}}, w_rd_word[31:24]};
            c_SZ_HALF:  w_ld_value = {{48{r_signed & w_rd_word[31]}}, w_rd_word[31:16]};
            c_SZ_DWORD: w_ld_value = {r_hi, w_rd_word};
            default:    w_ld_value = {32'd0, w_rd_word};
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_xfer && w_do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_en[i]) r_mem[w_lane_addr[i]] <= w_wr_word[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
            r_write    <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'b00;
            r_swap     <= 1'b0;
            r_addr     <= '0;
            r_data     <= 64'd0;
            r_err      <= 1'b0;
            r_hi       <= 32'd0;
            r_data_out <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write    <= write;
                r_signed   <= is_signed;
                r_size     <= size;
                r_swap     <= swap;
                r_addr     <= address;
                r_data     <= data_in;
                r_err      <= w_acc_err;
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if ((r_state == S_XFER1) && w_do_load) begin
                if (r_size == c_SZ_DWORD) r_hi       <= w_rd_word;
                else                      r_data_out <= w_ld_value;
            end
            if ((r_state == S_XFER2) && w_do_load) r_data_out <= w_ld_value;
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE);
    assign align_err = (r_state == S_DONE) && r_err;
    assign data_out  = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_sized_ram_ctrl.sv
// ============================================================================
// tb_sized_ram_ctrl : directed checks of sized_ram_ctrl (ADDR_WIDTH=8, WAIT_STATES=1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sized_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        write;
    logic        is_signed;
    logic [1:0]  size;
    logic        swap;
    logic [7:0]  address;
    logic [63:0] data_in;
    logic        ready;
    logic        done;
    logic [63:0] data_out;
    logic        align_err;

    int tests = 0;
    int fails = 0;

    sized_ram_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .write     (write),
        .is_signed (is_signed),
        .size      (size),
        .swap      (swap),
        .address   (address),
        .data_in   (data_in),
        .ready     (ready),
        .done      (done),
        .data_out  (data_out),
        .align_err (align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request; after the accept edge the inputs are scrambled and
    // req stays high, so neither latching nor queueing faults go unnoticed.
    task automatic issue(input logic w, input logic s, input logic [1:0] sz,
                         input logic sw, input logic [7:0] a, input logic [63:0] d,
                         input string tag);
        @(negedge clk);
        chk({tag, " ready"}, 64'(ready), 64'd1);
        req = 1'b1; write = w; is_signed = s; size = sz; swap = sw;
        address = a; data_in = d;
        @(posedge clk);
        #1;
        write = 1'b1; is_signed = ~s; size = 2'b11; swap = 1'b0;
        address = a ^ 8'h40; data_in = ~d;
    endtask

    task automatic complete(input int lat, input logic err, input string tag);
        int cnt = 0;
        bit seen = 1'b0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, " latency"}, 64'(cnt), 64'(lat));
        chk({tag, " align_err"}, 64'(align_err), 64'(err));
        req = 1'b0;
        @(negedge clk);
        chk({tag, " done/ready after"}, {62'd0, done, ready}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; write = 1'b0; is_signed = 1'b0; size = 2'b00;
        swap = 1'b0; address = 8'h00; data_in = 64'd0;
        #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset done", 64'(done), 64'd0);
        chk("reset align_err", 64'(align_err), 64'd0);
        chk("reset data_out", data_out, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(1, 0, 2'b10, 0, 8'h10, 64'hFFFF_0000_DEAD_BEEF, "st_w 10");
        complete(3, 0, "st_w 10");
        chk("store leaves data_out", data_out, 64'd0);

        issue(0, 0, 2'b10, 0, 8'h10, 64'd0, "ld_w 10");
        complete(3, 0, "ld_w 10");
        chk("ld_w 10 data", data_out, 64'h0000_0000_DEAD_BEEF);

        issue(1, 1, 2'b00, 0, 8'h21, 64'h1234_5678_9ABC_DE80, "st_b 21");
        complete(3, 0, "st_b 21");
        issue(0, 1, 2'b00, 0, 8'h21, 64'd0, "ld_b signed");
        complete(3, 0, "ld_b signed");
        chk("ld_b signed data", data_out, 64'hFFFF_FFFF_FFFF_FF80);
        issue(0, 0, 2'b00, 0, 8'h21, 64'd0, "ld_b unsigned");
        complete(3, 0, "ld_b unsigned");
        chk("ld_b unsigned data", data_out, 64'h0000_0000_0000_0080);

        issue(1, 0, 2'b11, 0, 8'h08, 64'h0123_4567_89AB_CDEF, "st_d 08");
        complete(4, 0, "st_d 08");
        chk("st_d leaves data_out", data_out, 64'h0000_0000_0000_0080);
        issue(0, 0, 2'b10, 0, 8'h0C, 64'd0, "ld_w 0C");
        complete(3, 0, "ld_w 0C");
        chk("ld_w 0C data", data_out, 64'h0000_0000_89AB_CDEF);
        issue(0, 1, 2'b10, 0, 8'h08, 64'd0, "ld_w 08");
        complete(3, 0, "ld_w 08");
        chk("ld_w 08 data", data_out, 64'h0000_0000_0123_4567);
        issue(0, 0, 2'b11, 0, 8'h08, 64'd0, "ld_d 08");
        complete(4, 0, "ld_d 08");
        chk("ld_d 08 data", data_out, 64'h0123_4567_89AB_CDEF);

        issue(0, 1, 2'b01, 0, 8'h10, 64'd0, "ld_h signed");
        complete(3, 0, "ld_h signed");
        chk("ld_h signed data", data_out, 64'hFFFF_FFFF_FFFF_DEAD);
        issue(0, 0, 2'b01, 0, 8'h12, 64'd0, "ld_h unsigned");
        complete(3, 0, "ld_h unsigned");
        chk("ld_h unsigned data", data_out, 64'h0000_0000_0000_BEEF);

        issue(0, 0, 2'b01, 0, 8'h03, 64'd0, "ld_h misaligned");
        complete(1, 1, "ld_h misaligned");
        chk("misaligned keeps data_out", data_out, 64'h0000_0000_0000_BEEF);
        issue(1, 0, 2'b10, 0, 8'h11, 64'h0000_0000_0BAD_F00D, "st_w misaligned");
        complete(1, 1, "st_w misaligned");
        issue(1, 0, 2'b11, 0, 8'h0C, 64'h5555_5555_6666_6666, "st_d misaligned");
        complete(1, 1, "st_d misaligned");
        issue(0, 0, 2'b10, 0, 8'h10, 64'd0, "ld_w 10 again");
        complete(3, 0, "ld_w 10 again");
        chk("misaligned store no write", data_out, 64'h0000_0000_DEAD_BEEF);
        issue(0, 0, 2'b10, 0, 8'h0C, 64'd0, "ld_w 0C again");
        complete(3, 0, "ld_w 0C again");
        chk("misaligned dword no write", data_out, 64'h0000_0000_89AB_CDEF);

        issue(1, 0, 2'b10, 0, 8'h30, 64'h0000_0000_CAFE_F00D, "st_w 30");
        complete(3, 0, "st_w 30");
        issue(1, 0, 2'b10, 0, 8'h34, 64'h0000_0000_0BAD_C0DE, "st_w 34");
        complete(3, 0, "st_w 34");
        issue(1, 0, 2'b11, 0, 8'h30, 64'h1111_1111_2222_2222, "st_d abort");
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort ready", 64'(ready), 64'd1);
        chk("abort done", 64'(done), 64'd0);
        chk("abort data_out", data_out, 64'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort no done", {62'd0, done, ready}, 64'd1);
        issue(0, 0, 2'b10, 0, 8'h30, 64'd0, "ld_w 30");
        complete(3, 0, "ld_w 30");
        chk("abort first half written", data_out, 64'h0000_0000_1111_1111);
        issue(0, 0, 2'b10, 0, 8'h34, 64'd0, "ld_w 34");
        complete(3, 0, "ld_w 34");
        chk("abort second half kept", data_out, 64'h0000_0000_0BAD_C0DE);

`ifdef SIZED_RAM_SWAP_EN
        issue(1, 0, 2'b10, 0, 8'h40, 64'h0000_0000_1111_2222, "st_w 40");
        complete(3, 0, "st_w 40");
        issue(0, 0, 2'b10, 1, 8'h40, 64'h0000_0000_3333_4444, "swap 40");
        complete(3, 0, "swap 40");
        chk("swap old word", data_out, 64'h0000_0000_1111_2222);
        issue(0, 0, 2'b10, 0, 8'h40, 64'd0, "ld_w 40");
        complete(3, 0, "ld_w 40");
        chk("swap new word", data_out, 64'h0000_0000_3333_4444);
        issue(0, 0, 2'b00, 1, 8'h40, 64'd0, "swap byte");
        complete(1, 1, "swap byte");
`else
        issue(0, 0, 2'b10, 1, 8'h10, 64'h0000_0000_5A5A_5A5A, "swap ignored");
        complete(3, 0, "swap ignored");
        chk("swap ignored data", data_out, 64'h0000_0000_DEAD_BEEF);
        issue(0, 0, 2'b10, 0, 8'h10, 64'd0, "swap ignored mem");
        complete(3, 0, "swap ignored mem");
        chk("swap ignored no write", data_out, 64'h0000_0000_DEAD_BEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sized_ram_ctrl.md
SIZED_RAM_CTRL -- requirements
Module: sized_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, byte-address width; array depth 2**ADDR_WIDTH bytes.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7, idle cycles inserted before each transfer.
REQ-003 Clk  input  1  rising-edge clock; one clock, all state on it.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Req  input  1  request, sampled at rising Clk only while Ready=1.
REQ-006 Write  input  1  1=store, 0=load.
REQ-007 Signed  input  1  sign-extend byte/halfword loads.
REQ-008 Size  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-009 Swap  input  1  atomic word swap request.
REQ-010 Address  input  ADDR_WIDTH  byte address, big-endian.
REQ-011 DataIn  input  64  store data, right-justified.
REQ-012 Ready  output  1  controller idle, request can be accepted.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 DataOut  output  64  load result, right-justified.
REQ-015 AlignErr  output  1  misaligned or illegal request; valid only with Done.

Function
REQ-016 States SHALL be IDLE, WAIT, XFER1, XFER2, DONE; Ready=1 only in IDLE.
REQ-017 On accept (Req=1 in IDLE), Write, Signed, Size, Swap, Address, DataIn SHALL be latched; later input changes have no effect.
REQ-018 Misaligned accept (halfword A[0]!=0, word A[1:0]!=0, doubleword A[2:0]!=0) SHALL go IDLE->DONE with AlignErr=1, no array change, DataOut unchanged.
REQ-019 Aligned accept SHALL go IDLE->WAIT for WAIT_STATES cycles (skipped when 0), then XFER1, XFER2 only for doubleword, then DONE, then IDLE.
REQ-020 Done SHALL go high exactly WAIT_STATES+2 cycles after the accept edge (WAIT_STATES+3 for doubleword), for one cycle.
REQ-021 Byte at Address SHALL be most significant; store byte/half/word SHALL write DataIn[7:0]/[15:0]/[31:0] in XFER1.
REQ-022 Doubleword store SHALL write DataIn[63:32] at A..A+3 in XFER1 and DataIn[31:0] at A+4..A+7 in XFER2.
REQ-023 Byte/half loads SHALL place data in DataOut[7:0]/[15:0], with the remaining bits zero, or copies of the data MSB when Signed=1.
REQ-024 Word loads SHALL fill DataOut[31:0] with DataOut[63:32]=0; doubleword loads fill DataOut[63:32] from A and [31:0] from A+4.
REQ-025 DataOut SHALL update only at the end of a load/swap transfer and hold until the next one; stores leave it unchanged.
REQ-026 Signed SHALL be ignored for word, doubleword and stores.
REQ-027 Req while Ready=0 SHALL be ignored, not queued.
REQ-028 Address arithmetic SHALL be modulo 2**ADDR_WIDTH.

Reset
REQ-029 Reset_n=0 SHALL immediately force IDLE, Ready=1, Done=0, AlignErr=0, DataOut=0, wait counter=0.
REQ-030 Array contents SHALL NOT be reset.
REQ-031 Reset mid-operation SHALL abort without Done; bytes already written (e.g. a doubleword's XFER1 word) remain.

Configuration
REQ-032 Macro SIZED_RAM_SWAP_EN SHALL compile in the swap feature.
REQ-033 With the macro, Swap=1 with Size=10 SHALL, in XFER1, load the old word into DataOut (zero-extended) and write DataIn[31:0], ignoring Write; Swap=1 with any other Size SHALL complete as an AlignErr.
REQ-034 Without the macro, Swap SHALL be ignored and the request SHALL behave per Write.

Verification
REQ-035 WAIT_STATES=1: word store 0xDEADBEEF @0x10, then word load @0x10 -> Done 3 cycles after accept, DataOut=0x00000000DEADBEEF.
REQ-036 Byte 0x80 stored @0x21, then byte load with Signed=1 -> DataOut=0xFFFFFFFFFFFFFF80; with Signed=0 -> 0x80.
REQ-037 Doubleword store 0x0123456789ABCDEF @0x08 -> Done 4 cycles after accept; word load @0x0C -> 0x89ABCDEF.
REQ-038 Halfword load @0x03 -> Done 1 cycle after accept, AlignErr=1, memory and DataOut unchanged.
REQ-039 Reset_n pulsed low during XFER2 of doubleword store @0x30 -> no Done, Ready=1; word @0x30 holds new data, word @0x34 holds old data.
REQ-040 With SIZED_RAM_SWAP_EN: word 0x11112222 @0x40, then swap with 0x33334444 -> DataOut=0x11112222, then load @0x40 -> 0x33334444.
